// File: rtl/div_pkg.sv
// div_pkg: FSM state type and counter sizing shared by the sequential divider.
package div_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rca_nbit.sv
// rca_nbit: W-bit ripple-carry adder; the carry out of the top bit is not produced.
module rca_nbit #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum
);
    logic [W-1:0] c;

    assign c[0] = cin;

    for (genvar g = 0; g < W; g++) begin : g_fa
        assign sum[g] = a[g] ^ b[g] ^ c[g];
        if (g < W - 1) begin : g_c
            assign c[g+1] = (a[g] & b[g]) | (c[g] & (a[g] ^ b[g]));
        end
    end

endmodule

// File: rtl/seq_divider_n_bit.sv
// seq_divider_n_bit: n-cycle unsigned restoring divider.
// Define DIV_ZERO_DETECT_EN to short-circuit y=0 straight to DONE with div_by_zero set.
module seq_divider_n_bit
    import div_pkg::*;
#(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] q,
    output logic [n-1:0] r,
    output logic         div_by_zero
);
    localparam int CW = cnt_w(n);
    localparam logic [CW-1:0] LAST = CW'(n - 1);
`ifdef DIV_ZERO_DETECT_EN
    localparam logic ZERO_DETECT = 1'b1;
`else
    localparam logic ZERO_DETECT = 1'b0;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [n-1:0]  rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d;
    logic [n-1:0]  q_q, q_d, r_q, r_d;
    logic          dz_q, dz_d, busy_q, busy_d, done_q, done_d;
    logic [n:0]    shifted, diff;
    logic          nonneg;

    assign shifted = {rem_q, dvd_q[n-1]};

    rca_nbit #(.W(n + 1)) u_sub (
        .a  (shifted),
        .b  (~{1'b0, dvs_q}),
        .cin(1'b1),
        .sum(diff)
    );

    // remainder stays below the divisor, so the (n+1)-bit difference fits as signed
    assign nonneg = ~diff[n];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: if (start) begin
                dvd_d   = x;
                dvs_d   = y;
                rem_d   = '0;
                cnt_d   = '0;
                state_d = RUN;
                if (ZERO_DETECT && y == '0) begin
                    state_d = DONE;
                    q_d     = '1;
                    r_d     = x;
                    dz_d    = 1'b1;
                end
            end
            RUN: begin
                rem_d = nonneg ? diff[n-1:0] : shifted[n-1:0];
                dvd_d = {dvd_q[n-2:0], nonneg};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    q_d     = dvd_d;
                    r_d     = rem_d;
                    dz_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d == RUN;
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign q           = q_q;
    assign r           = r_q;
    assign div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_divider_n_bit.sv
// tb_seq_divider_n_bit: directed checks of the 4-bit sequential divider.
module tb_seq_divider_n_bit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] x = '0;
    logic [3:0] y = '0;
    logic       busy, done, div_by_zero;
    logic [3:0] q, r;
    int tests = 0;
    int failed = 0;

    seq_divider_n_bit #(.n(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y),
        .busy(busy), .done(done), .q(q), .r(r), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // lat counts cycles from the start-accepting edge until done is seen
    task automatic run_div(input logic [3:0] xi, input logic [3:0] yi, output int lat, output int bcnt);
        @(negedge clk);
        x = xi; y = yi; start = 1'b1;
        @(negedge clk);
        start = 1'b0; x = ~xi; y = ~yi;
        lat = 0; bcnt = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({busy, done, q, r, div_by_zero} !== 11'd0) begin
            failed++;
            $display("FAIL reset: busy=%b done=%b q=%0d r=%0d dz=%b, want all 0", busy, done, q, r, div_by_zero);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [3:0] tv [3][4] = '{'{4'd13, 4'd3, 4'd4, 4'd1}, '{4'd11, 4'd5, 4'd2, 4'd1}, '{4'd14, 4'd4, 4'd3, 4'd2}};
        int lat, bcnt;
        for (int i = 0; i < 3; i++) begin
            run_div(tv[i][0], tv[i][1], lat, bcnt);
            tests++;
            if (lat !== 4 || bcnt !== 4) begin
                failed++;
                $display("FAIL basic%0d timing: latency=%0d busy_cycles=%0d, want 4/4", i, lat, bcnt);
            end
            tests++;
            if (q !== tv[i][2] || r !== tv[i][3] || div_by_zero !== 1'b0) begin
                failed++;
                $display("FAIL basic%0d result: q=%0d r=%0d dz=%b, want q=%0d r=%0d dz=0", i, q, r, div_by_zero, tv[i][2], tv[i][3]);
            end
            @(negedge clk);
            tests++;
            if (done !== 1'b0 || q !== tv[i][2] || r !== tv[i][3]) begin
                failed++;
                $display("FAIL basic%0d hold: done=%b q=%0d r=%0d, want done=0 q=%0d r=%0d", i, done, q, r, tv[i][2], tv[i][3]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int lat, bcnt;
        run_div(4'd15, 4'd1, lat, bcnt);
        tests++;
        if (lat !== 4 || q !== 4'd15 || r !== 4'd0) begin
            failed++;
            $display("FAIL b2b first: latency=%0d q=%0d r=%0d, want 4 q=15 r=0", lat, q, r);
        end
        run_div(4'd0, 4'd5, lat, bcnt);
        tests++;
        if (lat !== 4 || bcnt !== 4 || q !== 4'd0 || r !== 4'd0) begin
            failed++;
            $display("FAIL b2b second: latency=%0d busy=%0d q=%0d r=%0d, want 4/4 q=0 r=0", lat, bcnt, q, r);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0) begin
            failed++;
            $display("FAIL b2b pulse: done=%b one cycle after pulse, want 0", done);
        end
    endtask

    task automatic test_div_zero;
        int lat, bcnt;
`ifdef DIV_ZERO_DETECT_EN
        int exp_lat = 0;
        logic exp_dz = 1'b1;
`else
        int exp_lat = 4;
        logic exp_dz = 1'b0;
`endif
        run_div(4'd7, 4'd0, lat, bcnt);
        tests++;
        if (lat !== exp_lat || bcnt !== exp_lat) begin
            failed++;
            $display("FAIL div0 timing: latency=%0d busy=%0d, want %0d/%0d", lat, bcnt, exp_lat, exp_lat);
        end
        tests++;
        if (q !== 4'd15 || r !== 4'd7 || div_by_zero !== exp_dz) begin
            failed++;
            $display("FAIL div0 result: q=%0d r=%0d dz=%b, want q=15 r=7 dz=%b", q, r, div_by_zero, exp_dz);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || div_by_zero !== exp_dz) begin
            failed++;
            $display("FAIL div0 hold: done=%b dz=%b, want done=0 dz=%b", done, div_by_zero, exp_dz);
        end
    endtask

    task automatic test_ignore_start;
        int lat = 0;
        int extra = 0;
        @(negedge clk);
        x = 4'd9; y = 4'd2; start = 1'b1;
        @(negedge clk);
        x = 4'd1; y = 4'd1;
        @(negedge clk);
        start = 1'b0;
        while (!done && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        tests++;
        if (lat !== 3 || q !== 4'd4 || r !== 4'd1) begin
            failed++;
            $display("FAIL ignore result: cycles=%0d q=%0d r=%0d, want 3 q=4 r=1", lat, q, r);
        end
        repeat (8) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        tests++;
        if (extra !== 0) begin
            failed++;
            $display("FAIL ignore queued: %0d busy/done cycles after result, want 0", extra);
        end
    endtask

    task automatic test_reset_mid_run;
        int seen = 0;
        @(negedge clk);
        x = 4'd13; y = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
            failed++;
            $display("FAIL midrst busy: busy=%b in second RUN cycle, want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({busy, done, q, r} !== 10'd0) begin
            failed++;
            $display("FAIL midrst clear: busy=%b done=%b q=%0d r=%0d, want all 0", busy, done, q, r);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        tests++;
        if (seen !== 0) begin
            failed++;
            $display("FAIL midrst abort: %0d busy/done cycles after release, want 0", seen);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_div_zero;
        test_ignore_start;
        test_reset_mid_run;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
